// File: rtl/dot_seq_if.sv
// Command, memory and MAC signal bundle for the dot-product sequencer.
// The slave modport is the sequencer's view; master is the surrounding environment.
interface dot_seq_if #(
    parameter int T_WIDTH    = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int LEN_WIDTH  = 10
);
    logic                  start;
    logic [LEN_WIDTH-1:0]  len;
    logic [ADDR_WIDTH-1:0] base_a;
    logic [ADDR_WIDTH-1:0] base_b;
    logic [2:0]            mode_in;
    logic                  busy;
    logic                  done;
    logic [T_WIDTH-1:0]    result;

    logic [ADDR_WIDTH-1:0] mem_a_addr;
    logic                  mem_a_en;
    logic [T_WIDTH-1:0]    mem_a_data;
    logic [ADDR_WIDTH-1:0] mem_b_addr;
    logic                  mem_b_en;
    logic [T_WIDTH-1:0]    mem_b_data;

    logic [T_WIDTH-1:0]    mac_in_1;
    logic [T_WIDTH-1:0]    mac_in_2;
    logic                  mac_in_valid;
    logic                  mac_reset;
    logic [2:0]            mac_mode;
    logic [T_WIDTH-1:0]    mac_out;
    logic                  mac_out_valid;

    modport slave (
        input  start, len, base_a, base_b, mode_in,
        input  mem_a_data, mem_b_data, mac_out, mac_out_valid,
        output busy, done, result,
        output mem_a_addr, mem_a_en, mem_b_addr, mem_b_en,
        output mac_in_1, mac_in_2, mac_in_valid, mac_reset, mac_mode
    );

    modport master (
        output start, len, base_a, base_b, mode_in,
        output mem_a_data, mem_b_data, mac_out, mac_out_valid,
        input  busy, done, result,
        input  mem_a_addr, mem_a_en, mem_b_addr, mem_b_en,
        input  mac_in_1, mac_in_2, mac_in_valid, mac_reset, mac_mode
    );
endinterface

// File: rtl/dot_seq.sv
// Streams two operand vectors from synchronous-read memories into a fixed-point MAC
// and returns the MAC's truncated output after the last element as the dot product.
module dot_seq #(
    parameter int T_WIDTH    = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int LEN_WIDTH  = 10
) (
    input  logic       clk,
    input  logic       rst,
    dot_seq_if.slave   io
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_a_q, addr_a_d;
    logic [ADDR_WIDTH-1:0] addr_b_q, addr_b_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
    logic [2:0]            mode_q, mode_d;
    logic                  en_q, en_d;
    logic                  first_q, first_d;
    logic                  last_q, last_d;
    logic                  vld_q, vld_d;
    logic                  first_p_q, first_p_d;
    logic                  last_p_q, last_p_d;
    logic                  last_pp_q, last_pp_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [T_WIDTH-1:0]    result_q, result_d;

    // State register and every output flop; rst aborts any command in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            addr_a_q  <= {ADDR_WIDTH{1'b0}};
            addr_b_q  <= {ADDR_WIDTH{1'b0}};
            len_q     <= {LEN_WIDTH{1'b0}};
            cnt_q     <= {LEN_WIDTH{1'b0}};
            mode_q    <= 3'd0;
            en_q      <= 1'b0;
            first_q   <= 1'b0;
            last_q    <= 1'b0;
            vld_q     <= 1'b0;
            first_p_q <= 1'b0;
            last_p_q  <= 1'b0;
            last_pp_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= {T_WIDTH{1'b0}};
        end else begin
            state_q   <= state_d;
            addr_a_q  <= addr_a_d;
            addr_b_q  <= addr_b_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            mode_q    <= mode_d;
            en_q      <= en_d;
            first_q   <= first_d;
            last_q    <= last_d;
            vld_q     <= vld_d;
            first_p_q <= first_p_d;
            last_p_q  <= last_p_d;
            last_pp_q <= last_pp_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            result_q  <= result_d;
        end
    end

    // Next-state logic; read issue flops are set on the edge that enters each read cycle.
    always_comb begin
        state_d  = state_q;
        addr_a_d = addr_a_q;
        addr_b_d = addr_b_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        mode_d   = mode_q;
        en_d     = 1'b0;
        first_d  = 1'b0;
        last_d   = 1'b0;
        busy_d   = busy_q;
        done_d   = 1'b0;
        result_d = result_q;

        // Control pipeline: one stage to meet memory data, one more for mac_out_valid.
        vld_d     = en_q;
        first_p_d = en_q & first_q;
        last_p_d  = en_q & last_q;
        last_pp_d = last_p_q;

        case (state_q)
            S_IDLE: begin
                if (io.start) begin
                    busy_d = 1'b1;
                    if (io.len != {LEN_WIDTH{1'b0}}) begin
                        state_d  = S_RUN;
                        len_d    = io.len;
                        mode_d   = io.mode_in;
                        addr_a_d = io.base_a;
                        addr_b_d = io.base_b;
                        cnt_d    = {LEN_WIDTH{1'b0}};
                        en_d     = 1'b1;
                        first_d  = 1'b1;
                        last_d   = (io.len == LEN_WIDTH'(1));
                    end else begin
                        state_d = S_DONE;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (cnt_q == len_q - LEN_WIDTH'(1)) begin
                    state_d = S_DRAIN;
                end else begin
                    cnt_d    = cnt_q + LEN_WIDTH'(1);
                    addr_a_d = addr_a_q + ADDR_WIDTH'(1);
                    addr_b_d = addr_b_q + ADDR_WIDTH'(1);
                    en_d     = 1'b1;
                    last_d   = (cnt_q + LEN_WIDTH'(2) == len_q);
                end
            end
            S_DRAIN: begin
                if (io.mac_out_valid && last_pp_q) begin
                    state_d  = S_DONE;
                    result_d = io.mac_out;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_DONE: begin
                // A zero-length command arrives here without done set: pulse it now.
                if (done_q) begin
                    state_d = S_IDLE;
                end else begin
                    state_d  = S_DONE;
                    result_d = {T_WIDTH{1'b0}};
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign io.busy         = busy_q;
    assign io.done         = done_q;
    assign io.result       = result_q;
    assign io.mem_a_addr   = addr_a_q;
    assign io.mem_b_addr   = addr_b_q;
    assign io.mem_a_en     = en_q;
    assign io.mem_b_en     = en_q;
    assign io.mac_in_1     = io.mem_a_data;
    assign io.mac_in_2     = io.mem_b_data;
    assign io.mac_in_valid = vld_q;
    assign io.mac_reset    = first_p_q;
    assign io.mac_mode     = mode_q;
endmodule

// File: tb/tb_dot_seq.sv
// Directed bench for dot_seq with behavioural memories and a simple fixed-point MAC.
module tb_dot_seq;
    localparam int TW = 32;
    localparam int AW = 10;
    localparam int LW = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    dot_seq_if #(.T_WIDTH(TW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) bus ();

    dot_seq #(.T_WIDTH(TW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
        .clk (clk),
        .rst (rst),
        .io  (bus)
    );

    logic [TW-1:0] mem_a [0:1023];
    logic [TW-1:0] mem_b [0:1023];

    // Synchronous-read memories
    always @(posedge clk) begin
        if (bus.mem_a_en) bus.mem_a_data <= mem_a[bus.mem_a_addr];
        if (bus.mem_b_en) bus.mem_b_data <= mem_b[bus.mem_b_addr];
    end

    // MAC model: 64-bit accumulation, mode 1 selects Q16.16, other modes the low word
    logic signed [63:0] acc;
    logic               acc_vld;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            acc     <= 64'sd0;
            acc_vld <= 1'b0;
        end else begin
            acc_vld <= bus.mac_in_valid;
            if (bus.mac_in_valid)
                acc <= (bus.mac_reset ? 64'sd0 : acc)
                       + $signed(bus.mac_in_1) * $signed(bus.mac_in_2);
        end
    end
    assign bus.mac_out       = (bus.mac_mode == 3'd1) ? acc[47:16] : acc[31:0];
    assign bus.mac_out_valid = acc_vld;

    // Event monitor sampled on the falling edge
    int en_cnt = 0;
    int vld_cnt = 0;
    int mrst_cnt = 0;
    int done_cnt = 0;
    int addr_log [0:255];
    logic rst_log [0:255];
    always @(negedge clk) begin
        if (bus.mem_a_en) begin
            addr_log[en_cnt[7:0]] <= int'(bus.mem_a_addr);
            en_cnt <= en_cnt + 1;
        end
        if (bus.mac_in_valid) begin
            rst_log[vld_cnt[7:0]] <= bus.mac_reset;
            vld_cnt <= vld_cnt + 1;
        end
        if (bus.mac_reset) mrst_cnt <= mrst_cnt + 1;
        if (bus.done) done_cnt <= done_cnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issue one command from a falling edge; lat = rising edges from the sampling edge to done.
    task automatic run_cmd(input int n, input int ba, input int bb, input int mode,
                           input int glitch_at, input string tag, output int lat);
        int k;
        bus.start   = 1'b1;
        bus.len     = LW'(n);
        bus.base_a  = AW'(ba);
        bus.base_b  = AW'(bb);
        bus.mode_in = 3'(mode);
        @(negedge clk);
        bus.start = 1'b0;
        if (n != 0) check({tag, "_busy"}, 64'(bus.busy), 64'd1);
        k = 0;
        while (!bus.done && k < 200) begin
            @(negedge clk);
            k++;
            bus.start = (k == glitch_at);
            if (k == glitch_at) begin
                bus.len     = LW'(1);
                bus.base_a  = AW'(5);
                bus.base_b  = AW'(6);
                bus.mode_in = 3'd3;
            end
        end
        bus.start = 1'b0;
        lat = k;
        check({tag, "_busy_at_done"}, 64'(bus.busy), 64'd0);
    endtask

    int lat, e0, v0, r0, d0;

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem_a[i] = 32'h0;
            mem_b[i] = 32'h0;
        end
        mem_a[0] = 32'd1; mem_a[1] = 32'd2; mem_a[2] = 32'd3;
        mem_b[0] = 32'd4; mem_b[1] = 32'd5; mem_b[2] = 32'd6;
        mem_a[10] = 32'h0001_8000; mem_a[11] = 32'hFFFF_0000;
        mem_b[20] = 32'h0002_0000; mem_b[21] = 32'h0001_0000;
        mem_a[1022] = 32'd2; mem_a[1023] = 32'd3;
        mem_b[500] = 32'd10; mem_b[501] = 32'd20; mem_b[502] = 32'd30; mem_b[503] = 32'd40;
        mem_a[100] = 32'd5; mem_a[101] = 32'd6; mem_b[200] = 32'd7; mem_b[201] = 32'd8;
        mem_a[102] = 32'hFFFF_FFFE; mem_a[103] = 32'd3; mem_b[202] = 32'd4; mem_b[203] = 32'd1;
        mem_a[300] = 32'd9; mem_a[301] = 32'd9; mem_a[302] = 32'd9;
        mem_b[300] = 32'd9; mem_b[301] = 32'd9; mem_b[302] = 32'd9;
        mem_a[400] = 32'd7; mem_b[400] = 32'hFFFF_FFFD;
        bus.start = 1'b0; bus.len = '0; bus.base_a = '0; bus.base_b = '0; bus.mode_in = 3'd0;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy",   64'(bus.busy), 64'd0);
        check("rst_done",   64'(bus.done), 64'd0);
        check("rst_result", 64'(bus.result), 64'd0);
        check("rst_en",     64'({bus.mem_a_en, bus.mem_b_en}), 64'd0);
        check("rst_addr",   64'({bus.mem_a_addr, bus.mem_b_addr}), 64'd0);
        check("rst_mac",    64'({bus.mac_in_valid, bus.mac_reset, bus.mac_mode}), 64'd0);

        // mode 0, N=3: 1*4 + 2*5 + 3*6 = 32
        e0 = en_cnt; v0 = vld_cnt; r0 = mrst_cnt; d0 = done_cnt;
        run_cmd(3, 0, 0, 0, -1, "t1", lat);
        #1;
        check("t1_lat",    64'(lat), 64'd5);
        check("t1_result", 64'(bus.result), 64'd32);
        check("t1_reads",  64'(en_cnt - e0), 64'd3);
        check("t1_mrst",   64'(mrst_cnt - r0), 64'd1);
        check("t1_mrst_first", 64'(rst_log[v0[7:0]]), 64'd1);
        check("t1_done_cnt", 64'(done_cnt - d0), 64'd1);
        @(negedge clk);
        check("t1_done_pulse", 64'(bus.done), 64'd0);

        // mode 1 Q16.16: 1.5*2.0 + (-1.0)*1.0 = 2.0
        @(negedge clk);
        run_cmd(2, 10, 20, 1, -1, "t2", lat);
        check("t2_lat",    64'(lat), 64'd4);
        check("t2_result", 64'(bus.result), 64'h0002_0000);
        check("t2_mode",   64'(bus.mac_mode), 64'd1);

        // zero length
        @(negedge clk);
        e0 = en_cnt; v0 = vld_cnt;
        run_cmd(0, 7, 7, 0, -1, "t3", lat);
        #1;
        check("t3_lat",    64'(lat), 64'd1);
        check("t3_result", 64'(bus.result), 64'd0);
        check("t3_reads",  64'(en_cnt - e0), 64'd0);
        check("t3_valids", 64'(vld_cnt - v0), 64'd0);

        // address wrap plus a stray start while busy: 2*10 + 3*20 + 1*30 + 2*40 = 190
        @(negedge clk);
        e0 = en_cnt; d0 = done_cnt;
        run_cmd(4, 1022, 500, 0, 2, "t4", lat);
        repeat (6) @(negedge clk);
        #1;
        check("t4_lat",    64'(lat), 64'd6);
        check("t4_result", 64'(bus.result), 64'd190);
        check("t4_reads",  64'(en_cnt - e0), 64'd4);
        check("t4_addr0",  64'(addr_log[e0[7:0]]), 64'd1022);
        check("t4_addr1",  64'(addr_log[8'(e0 + 1)]), 64'd1023);
        check("t4_addr2",  64'(addr_log[8'(e0 + 2)]), 64'd0);
        check("t4_addr3",  64'(addr_log[8'(e0 + 3)]), 64'd1);
        check("t4_one_done", 64'(done_cnt - d0), 64'd1);

        // back-to-back: 5*7+6*8 = 83, then -2*4 + 3*1 = -5
        @(negedge clk);
        run_cmd(2, 100, 200, 0, -1, "t5a", lat);
        check("t5a_lat",    64'(lat), 64'd4);
        check("t5a_result", 64'(bus.result), 64'd83);
        @(negedge clk);
        run_cmd(2, 102, 202, 0, -1, "t5b", lat);
        check("t5b_lat",    64'(lat), 64'd4);
        check("t5b_result", 64'(bus.result), 64'hFFFF_FFFB);

        // async reset during RUN at i=1, then 7 * -3 = -21
        @(negedge clk);
        d0 = done_cnt;
        bus.start = 1'b1; bus.len = LW'(3); bus.base_a = AW'(300); bus.base_b = AW'(300);
        bus.mode_in = 3'd2;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        check("t6_pre_en", 64'(bus.mem_a_en), 64'd1);
        rst = 1'b1;
        #1;
        check("t6_busy",   64'(bus.busy), 64'd0);
        check("t6_done",   64'(bus.done), 64'd0);
        check("t6_result", 64'(bus.result), 64'd0);
        check("t6_en",     64'({bus.mem_a_en, bus.mem_b_en}), 64'd0);
        check("t6_addr",   64'({bus.mem_a_addr, bus.mem_b_addr}), 64'd0);
        check("t6_mac",    64'({bus.mac_in_valid, bus.mac_reset, bus.mac_mode}), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        check("t6_no_done", 64'(done_cnt - d0), 64'd0);
        @(negedge clk);
        run_cmd(1, 400, 400, 0, -1, "t6b", lat);
        check("t6b_lat",    64'(lat), 64'd3);
        check("t6b_result", 64'(bus.result), 64'hFFFF_FFEB);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
